// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider:
//   state_t    - control FSM state encoding (IDLE, RUN, FIX, DONE)
//   cnt_width  - width of the step counter needed for a given operand width
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter must be able to hold 0 .. width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division step (purely combinational).
// Ports:
//   rem       in  WIDTH+1  current partial remainder
//   quo       in  WIDTH    current quotient / dividend shift register
//   divisor   in  WIDTH    divisor magnitude
//   rem_next  out WIDTH+1  partial remainder after this step
//   quo_next  out WIDTH    shift register after this step (new LSB = quotient bit)
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           fits;

    // Shift {rem, quo} left by one; the MSB of quo enters the remainder.
    assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};

    // A set rem MSB would be shifted out as a carry, meaning the shifted value
    // certainly exceeds the divisor; otherwise a clear trial MSB means no borrow.
    assign fits     = rem[WIDTH] | ~trial[WIDTH];
    assign rem_next = fits ? trial : shifted;
    assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Sequential restoring divider, one quotient bit per clock, unsigned or
// two's-complement signed.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request, sampled only in IDLE
//   signed_mode  in   1 = signed, 0 = unsigned (captured with start)
//   dividend     in   WIDTH, captured with start
//   divisor      in   WIDTH, captured with start
//   busy         out  high in every state except IDLE
//   done         out  single-cycle pulse, results valid from this cycle on
//   quotient     out  WIDTH result
//   remainder    out  WIDTH result
//   div_by_zero  out  set with done when the divisor was zero
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic             dvd_neg_q;     // dividend was negative (signed mode only)
    logic             dvs_neg_q;     // divisor was negative (signed mode only)
    logic             dbz_pend_q;    // divide-by-zero seen, published at DONE
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic             dvd_neg_in;
    logic             dvs_neg_in;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;

    assign dvd_neg_in = signed_mode & dividend[WIDTH-1];
    assign dvs_neg_in = signed_mode & divisor[WIDTH-1];
    assign dvd_mag    = dvd_neg_in ? -dividend : dividend;
    assign dvs_mag    = dvs_neg_in ? -divisor  : divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (div_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            dbz_pend_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        dbz_q  <= 1'b0;
                        cnt_q  <= '0;
                        if (divisor == '0) begin
                            // Results are fixed: all-ones quotient, raw dividend.
                            quo_q      <= '1;
                            rem_q      <= {1'b0, dividend};
                            div_q      <= '0;
                            dvd_neg_q  <= 1'b0;
                            dvs_neg_q  <= 1'b0;
                            dbz_pend_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            quo_q      <= dvd_mag;
                            rem_q      <= '0;
                            div_q      <= dvs_mag;
                            dvd_neg_q  <= dvd_neg_in;
                            dvs_neg_q  <= dvs_neg_in;
                            dbz_pend_q <= 1'b0;
                            state_q    <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FIX: begin
                    // Quotient sign = XOR of operand signs; remainder follows dividend.
                    if (dvd_neg_q ^ dvs_neg_q) begin
                        quo_q <= -quo_q;
                    end
                    if (dvd_neg_q) begin
                        rem_q <= {1'b0, -rem_q[WIDTH-1:0]};
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    quotient_q  <= quo_q;
                    remainder_q <= rem_q[WIDTH-1:0];
                    dbz_q       <= dbz_pend_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // 32-bit instance
    logic        start32 = 1'b0;
    logic        sm32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        busy32, done32, dbz32;
    logic [31:0] q32, r32;

    // 8-bit instance
    logic        start8 = 1'b0;
    logic        sm8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  q8, r8;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .signed_mode(sm32),
        .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .div_by_zero(dbz32)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Run one 32-bit division. inject >= 0 pulses start with junk operands
    // that many edges after the accepting edge.
    task automatic run32(input string tag, input logic sm, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int elat, input int inject);
        int n;
        @(negedge clk);
        start32 = 1'b1; sm32 = sm; a32 = a; b32 = b;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        // Operand changes after capture must not matter.
        a32 = 32'h1234_5678; b32 = 32'h0000_0003; sm32 = ~sm;
        check({tag, "_busy_hi"}, {31'b0, busy32}, 32'd1);
        check({tag, "_dbz_clr"}, {31'b0, dbz32}, 32'd0);
        n = 0;
        while (!done32 && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == inject) begin
                start32 = 1'b1; a32 = 32'd999; b32 = 32'd10;
            end else begin
                start32 = 1'b0;
            end
        end
        start32 = 1'b0;
        check({tag, "_lat"}, n, elat);
        check({tag, "_q"}, q32, eq);
        check({tag, "_r"}, r32, er);
        check({tag, "_dbz"}, {31'b0, dbz32}, {31'b0, edz});
        check({tag, "_busy_lo"}, {31'b0, busy32}, 32'd0);
        $display("txn w32 %s sm=%0b a=0x%08h b=0x%08h -> q=0x%08h r=0x%08h dbz=%0b lat=%0d",
                 tag, sm, a, b, q32, r32, dbz32, n);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'b0, done32}, 32'd0);
    endtask

    function automatic logic [16:0] model8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, qi, ri;
        logic [7:0] qo, ro;
        if (b == 8'd0) begin
            qo = 8'hFF; ro = a;
        end else if (!sm) begin
            qo = a / b; ro = a % b;
        end else begin
            sa = int'($signed(a)); sb = int'($signed(b));
            qi = sa / sb; ri = sa % sb;
            qo = qi[7:0]; ro = ri[7:0];
        end
        return {(b == 8'd0), qo, ro};
    endfunction

    task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        int n;
        int elat;
        logic [16:0] exp;
        exp  = model8(sm, a, b);
        elat = (b == 8'd0) ? 1 : 10;
        @(negedge clk);
        start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = 8'd0;
        n = 0;
        while (!done8 && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("w8_lat", n, elat);
        check("w8_q", {24'b0, q8}, {24'b0, exp[15:8]});
        check("w8_r", {24'b0, r8}, {24'b0, exp[7:0]});
        check("w8_dbz", {31'b0, dbz8}, {31'b0, exp[16]});
        $display("txn w8 sm=%0b a=0x%02h b=0x%02h -> q=0x%02h r=0x%02h dbz=%0b lat=%0d",
                 sm, a, b, q8, r8, dbz8, n);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy32}, 32'd0);
        check("rst_done", {31'b0, done32}, 32'd0);
        check("rst_q", q32, 32'd0);
        check("rst_r", r32, 32'd0);
        check("rst_dbz", {31'b0, dbz32}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed 32-bit vectors
        run32("u_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34, -1);
        run32("s_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34, -1);
        run32("s_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 34, -1);
        run32("s_m7_m2",   1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 34, -1);
        run32("u_5_0",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1,  -1);
        run32("u_after0",  1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34, -1);
        run32("s_5_0",     1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1,  -1);
        run32("s_min_m1",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34, -1);
        run32("u_min_m1",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 34, -1);
        run32("u_big",     1'b0, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  32'd15,         1'b0, 34, -1);
        // Start pulsed mid-RUN is ignored
        run32("u_ignore",  1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34, 5);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        start32 = 1'b1; sm32 = 1'b0; a32 = 32'd1000; b32 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy32}, 32'd0);
        check("arst_done", {31'b0, done32}, 32'd0);
        check("arst_q", q32, 32'd0);
        check("arst_r", r32, 32'd0);
        check("arst_dbz", {31'b0, dbz32}, 32'd0);
        $display("txn w32 async reset mid-run q=0x%08h r=0x%08h busy=%0b", q32, r32, busy32);
        @(negedge clk);
        rst_n = 1'b1;
        run32("post_rst",  1'b0, 32'd1000,       32'd3,          32'd333,        32'd1,          1'b0, 34, -1);

        // 8-bit sweep against the reference model
        run8(1'b0, 8'hFF, 8'h01);
        run8(1'b1, 8'hFF, 8'h01);
        run8(1'b0, 8'h00, 8'h05);
        run8(1'b1, 8'h00, 8'h05);
        run8(1'b1, 8'h80, 8'hFF);
        run8(1'b0, 8'h80, 8'hFF);
        run8(1'b0, 8'h2A, 8'h00);
        run8(1'b1, 8'hF3, 8'h00);
        for (int i = 0; i < 24; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run8(i[0], ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
